// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the 12-bit SPI link (transmitter and receiver).
// Idle line levels double as synchroniser reset values so reset never fabricates an edge.
package spi_pkg;

    localparam int SPI_DATA_W    = 12;
    localparam int SPI_LEAD_BITS = 1;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus a previous flop giving single-cycle rise/fall strobes.
// Edges appear two clk edges after the pin changes; no backpressure.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic       meta;
    logic       prev;
    logic [2:0] fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
            fill <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
            fill <= {fill[1:0], 1'b1};
        end
    end

    // Edges are masked until prev holds a real pin sample, so a line already
    // active when reset releases is not mistaken for a fresh transition.
    assign rise = fill[2] & ~prev &  sync;
    assign fall = fill[2] &  prev & ~sync;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver: oversamples cs/sclk/mosi in clk, rebuilds each frame, flags truncated ones.
// valid and new dout land 3 clk edges after cs rises at the pin; no backpressure (one word per frame).
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int LEAD_BITS = SPI_LEAD_BITS,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int LEAD_W = (LEAD_BITS > 0) ? $clog2(LEAD_BITS + 1) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W);
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEAD_BITS);

    spi_state_t        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_inc;
    logic [LEAD_W-1:0] lead_cnt, lead_inc;
    logic [DATA_W-1:0] sreg;

    logic sclk_fall, cs_fall, cs_rise, mosi_s;
    logic sclk_s_unused, sclk_rise_unused, cs_s_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_s_unused),
        .rise (sclk_rise_unused),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(CS_IDLE)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs),
        .sync (cs_s_unused),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.RST_VAL(MOSI_IDLE)) u_mosi_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .sync (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    assign bit_inc  = bit_cnt + CNT_W'(1);
    assign lead_inc = lead_cnt + LEAD_W'(1);
    assign busy     = (state != IDLE);

    // cs_rise is tested first everywhere: a coincident sclk_fall is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cs_fall) state_nxt = (LEAD_BITS == 0) ? SHIFT : SKIP;
            SKIP:  if (cs_rise) state_nxt = IDLE;
                   else if (sclk_fall && lead_inc == LEAD_LAST) state_nxt = SHIFT;
            SHIFT: if (cs_rise) state_nxt = IDLE;
                   else if (sclk_fall && bit_inc == BIT_LAST) state_nxt = HOLD;
            HOLD:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            lead_cnt  <= '0;
            sreg      <= '0;
        end else begin
            state     <= state_nxt;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        lead_cnt <= '0;
                        sreg     <= '0;
                    end
                end
                SKIP: begin
                    if (cs_rise)        frame_err <= 1'b1;
                    else if (sclk_fall) lead_cnt  <= lead_inc;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                    end else if (sclk_fall) begin
                        bit_cnt <= bit_inc;
                        if (LSB_FIRST) sreg[bit_cnt] <= mosi_s;
                        else           sreg <= {sreg[DATA_W-2:0], mosi_s};
                    end
                end
                HOLD: begin
                    if (cs_rise) begin
                        dout  <= sreg;
                        valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
